// File: rtl/print_line_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// print_pkg
//   Shared definitions for the thermal-print line sequencer: sequencer state
//   encoding, default geometry of the line buffer and a small constant helper.
//   No ports.
// -----------------------------------------------------------------------------
package print_pkg;

  localparam int DOTS_PER_LINE_DEF = 384;
  localparam int ADDR_W_DEF        = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_LATCH     = 3'd3,
    ST_STROBE    = 3'd4,
    ST_STEP      = 3'd5,
    ST_WAIT_STEP = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  // Larger of two integers, used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/print_line_sequencer_head_shifter.sv
// -----------------------------------------------------------------------------
// head_shifter
//   Serialises one byte to the print head, MSB first. Each bit is presented on
//   do_o with the shift clock low for CLK_DIV cycles, then with the shift clock
//   high for CLK_DIV cycles, so the head samples a stable bit on the rising
//   edge. Both outputs are plain registers and are 0 whenever no byte is active.
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   clear_i      synchronous cancel, drops any byte in progress
//   load_i       capture data_i and start shifting on the next cycle
//   data_i[7:0]  byte to serialise
//   do_o         serial dot data
//   sclk_o       head shift clock
//   byte_done_o  high in the last cycle of the byte (end of bit 7 high half)
// -----------------------------------------------------------------------------
module head_shifter
  import print_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       do_o,
  output logic       sclk_o,
  output logic       byte_done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic             active_q, active_d;
  logic             half_end_s;

  assign half_end_s  = (div_q == DIV_W'(CLK_DIV - 1));
  assign byte_done_o = active_q & phase_q & half_end_s & (bit_q == 3'd7);
  assign do_o        = shreg_q[7];
  assign sclk_o      = phase_q;

  // Next-state logic: load, half-period timing and bit advance.
  always_comb begin
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    phase_d  = phase_q;
    active_d = active_q;
    if (clear_i) begin
      shreg_d  = 8'h00;
      bit_d    = 3'd0;
      div_d    = '0;
      phase_d  = 1'b0;
      active_d = 1'b0;
    end else if (load_i) begin
      shreg_d  = data_i;
      bit_d    = 3'd0;
      div_d    = '0;
      phase_d  = 1'b0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (half_end_s) begin
        div_d = '0;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          // Shift on the falling edge; clear the register after bit 7 so DO idles low.
          if (bit_q == 3'd7) begin
            active_d = 1'b0;
            shreg_d  = 8'h00;
            bit_d    = 3'd0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q  <= 8'h00;
      bit_q    <= 3'd0;
      div_q    <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/print_line_sequencer.sv
// -----------------------------------------------------------------------------
// print_line_sequencer
//   Prints one thermal line: fetches DOTS_PER_LINE/8 bytes from a synchronous
//   line buffer, shifts them to the head, pulses LAT, burns with STB, then
//   requests STEPS_PER_LINE paper-feed steps and pulses done.
//   Optional feature macro SKIP_BLANK_EN: when defined, a line whose bytes are
//   all zero skips the STB burn phase (LATCH goes straight to STEP).
// Ports
//   CLK        system clock            reset     async active-high reset
//   start      line ready (level)      abort     synchronous cancel
//   rd_addr    line-buffer address     rd_data   byte, 1 cycle after rd_addr
//   DO/CLKimpr head data / shift clock LAT/STB   latch / burn strobe
//   step_req   1-cycle step request    step_done 1-cycle step completion
//   busy       line in progress        done      1-cycle line-complete pulse
// -----------------------------------------------------------------------------
module print_line_sequencer
  import print_pkg::*;
#(
  parameter int DOTS_PER_LINE  = DOTS_PER_LINE_DEF,
  parameter int CLK_DIV        = 4,
  parameter int LAT_CYCLES     = 10,
  parameter int STB_CYCLES     = 50000,
  parameter int STEPS_PER_LINE = 2,
  parameter int ADDR_W         = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              DO,
  output logic              CLKimpr,
  output logic              LAT,
  output logic              STB,
  output logic              step_req,
  input  logic              step_done,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = DOTS_PER_LINE / 8;
  localparam int CNT_W  = $clog2(max_int(LAT_CYCLES, STB_CYCLES) + 1);
  localparam int STEP_W = $clog2(STEPS_PER_LINE + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ph_q, ph_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              lat_q, lat_d, stb_q, stb_d, req_q, req_d;
  logic              abort_s, load_s, byte_done_s, skip_s;

  // Abort is only meaningful once a line is in flight.
  assign abort_s = abort && (state_q != ST_IDLE);
  // Second LOAD cycle: rd_data now reflects rd_addr issued in the first.
  assign load_s  = (state_q == ST_LOAD) && ph_q;

  head_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk_i       (CLK),
    .rst_i       (reset),
    .clear_i     (abort_s),
    .load_i      (load_s),
    .data_i      (rd_data),
    .do_o        (DO),
    .sclk_o      (CLKimpr),
    .byte_done_o (byte_done_s)
  );

`ifdef SKIP_BLANK_EN
  logic inked_q, inked_d;

  // Track whether any loaded byte of the current line has a dot set.
  always_comb begin
    inked_d = inked_q;
    if (state_q == ST_IDLE) begin
      inked_d = 1'b0;
    end else if (load_s) begin
      inked_d = inked_q | (|rd_data);
    end else begin
      inked_d = inked_q;
    end
  end

  // Blank-line tracker register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      inked_q <= 1'b0;
    end else begin
      inked_q <= inked_d;
    end
  end

  assign skip_s = ~inked_q;
`else
  assign skip_s = 1'b0;
`endif

  // Sequencer next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    if (abort_s) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      ph_d    = 1'b0;
      cnt_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            addr_d  = '0;
            ph_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d    = 1'b0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!byte_done_s) begin
            state_d = ST_SHIFT;
          end else if (addr_q == ADDR_W'(NBYTES - 1)) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_LOAD;
          end
        end
        ST_LATCH: begin
          if (cnt_q == CNT_W'(LAT_CYCLES - 1)) begin
            cnt_d   = '0;
            step_d  = '0;
            state_d = skip_s ? ST_STEP : ST_STROBE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (cnt_q == CNT_W'(STB_CYCLES - 1)) begin
            cnt_d   = '0;
            step_d  = '0;
            state_d = ST_STEP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STEP: begin
          // step_done in this cycle is not accepted; only WAIT_STEP listens.
          step_d  = step_q + STEP_W'(1);
          state_d = ST_WAIT_STEP;
        end
        ST_WAIT_STEP: begin
          if (!step_done) begin
            state_d = ST_WAIT_STEP;
          end else if (step_q == STEP_W'(STEPS_PER_LINE)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STEP;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
        default: begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
      endcase
    end
    // Outputs are registered copies of the upcoming state so they align with it.
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
    lat_d  = (state_d == ST_LATCH);
    stb_d  = (state_d == ST_STROBE);
    req_d  = (state_d == ST_STEP);
  end

  // Sequencer registers; async reset drops STB immediately for head safety.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lat_q   <= 1'b0;
      stb_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lat_q   <= lat_d;
      stb_q   <= stb_d;
      req_q   <= req_d;
    end
  end

  assign rd_addr  = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign LAT      = lat_q;
  assign STB      = stb_q;
  assign step_req = req_q;

endmodule

// File: tb/tb_print_line_sequencer.sv
// Scoreboard bench for print_line_sequencer: the stimulus process pushes the
// expected per-line result, a monitor process observes the head/motor outputs
// of each line and compares when the line ends.
module tb_print_line_sequencer;

  localparam int DOTS  = 16;
  localparam int CDIV  = 2;
  localparam int LATC  = 3;
  localparam int STBC  = 20;
  localparam int STEPS = 2;
  localparam int AW    = 6;
  localparam int NB    = DOTS / 8;

  logic          CLK;
  logic          reset, start, abort, step_done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          DO, CLKimpr, LAT, STB, step_req, busy, done;

  print_line_sequencer #(
    .DOTS_PER_LINE(DOTS), .CLK_DIV(CDIV), .LAT_CYCLES(LATC),
    .STB_CYCLES(STBC), .STEPS_PER_LINE(STEPS), .ADDR_W(AW)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .DO(DO), .CLKimpr(CLKimpr),
    .LAT(LAT), .STB(STB), .step_req(step_req), .step_done(step_done),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous line-buffer model.
  logic [7:0] mem [NB];
  always @(posedge CLK) rd_data <= (int'(rd_addr) < NB) ? mem[int'(rd_addr)] : 8'h00;

  typedef struct {
    bit             completed;
    logic [DOTS-1:0] dots;
    int             rises;
    int             lat;
    int             stb;
    int             steps;
    int             latency;
    int             gap;
  } line_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  line_t exp_q[$];
  dchk_t dir_q[$];

  int checks = 0, errors = 0;
  int lines_seen = 0, lines_target = 0;
  int step_delay = 1;
  int poke_cnt = 0, poke_seen = 0;

  // Reference model: what one full line should look like from the outside.
  function automatic line_t model_line(input int delay, input int gap);
    line_t e;
    logic [DOTS-1:0] d;
    d = '0;
    for (int i = 0; i < NB; i++) d = {d[DOTS-9:0], mem[i]};
    e.completed = 1'b1;
    e.dots      = d;
    e.rises     = DOTS;
    e.lat       = LATC;
    e.stb       = STBC;
`ifdef SKIP_BLANK_EN
    if (d == '0) e.stb = 0;
`endif
    e.steps   = STEPS;
    e.latency = 1 + NB * (2 + 16 * CDIV) + LATC + e.stb + STEPS * (1 + delay) + 1;
    e.gap     = gap;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic dchk(input string name, input int act, input int exp);
    dchk_t d;
    d.name = name; d.act = act; d.exp = exp;
    dir_q.push_back(d);
  endtask

  // Motor driver model: answers step_req after step_delay cycles; poke_cnt forces a stray pulse.
  initial begin
    step_done = 1'b0;
    forever begin
      @(negedge CLK);
      step_done = 1'b0;
      if (poke_cnt != poke_seen) begin
        poke_seen = poke_cnt;
        step_done = 1'b1;
      end else if (step_req) begin
        repeat (step_delay) @(negedge CLK);
        step_done = 1'b1;
      end
    end
  end

  // Monitor: accumulate each line's observable behaviour and score it when busy drops.
  initial begin : monitor
    bit              in_line;
    bit              prev_clk;
    logic [DOTS-1:0] bits;
    int rises, lat_n, stb_n, step_n, busy_n, idle_run, gap_seen;
    line_t e;
    dchk_t d;
    in_line = 0; prev_clk = 0; bits = '0; idle_run = 1000; gap_seen = 0;
    rises = 0; lat_n = 0; stb_n = 0; step_n = 0; busy_n = 0;
    forever begin
      @(negedge CLK);
      while (dir_q.size() > 0) begin
        d = dir_q.pop_front();
        chk(d.name, d.act, d.exp);
      end
      if (reset) begin
        in_line = 0;
        prev_clk = 0;
      end else begin
        if (!in_line && busy) begin
          in_line = 1; gap_seen = idle_run; bits = '0;
          rises = 0; lat_n = 0; stb_n = 0; step_n = 0; busy_n = 0;
        end
        if (in_line) begin
          if (CLKimpr && !prev_clk) begin
            rises++;
            bits = {bits[DOTS-2:0], DO};
          end
          if (LAT) lat_n++;
          if (STB) stb_n++;
          if (step_req) step_n++;
          if (busy) begin
            busy_n++;
          end else begin
            if (exp_q.size() == 0) begin
              chk("unexpected_line", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("done_pulse", int'(done), int'(e.completed));
              chk("dots", int'(bits), int'(e.dots));
              chk("clk_rises", rises, e.rises);
              chk("lat_cycles", lat_n, e.lat);
              chk("stb_cycles", stb_n, e.stb);
              chk("step_reqs", step_n, e.steps);
              if (e.completed) chk("latency", busy_n + 2, e.latency);
              if (e.gap >= 0) chk("gap", gap_seen, e.gap);
            end
            lines_seen++;
            in_line = 0;
            idle_run = 0;
          end
        end else begin
          idle_run++;
          chk("idle_quiet", int'({DO, CLKimpr, LAT, STB, step_req, done}), 0);
        end
        prev_clk = CLKimpr;
      end
    end
  end

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic wait_lines(input int target, input int budget);
    int n;
    n = 0;
    while (lines_seen < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (lines_seen < target) dchk("line_timeout", lines_seen, target);
  endtask

  task automatic run_line(input int delay);
    step_delay = delay;
    exp_q.push_back(model_line(delay, -1));
    lines_target++;
    pulse_start();
    wait_lines(lines_target, 2000);
    repeat (4) @(negedge CLK);
  endtask

  // Stimulus.
  initial begin : stim
    line_t e;
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < NB; i++) mem[i] = 8'h00;
    repeat (3) @(negedge CLK);
    dchk("rst_outputs", int'({DO, CLKimpr, LAT, STB, step_req, busy, done}), 0);
    dchk("rst_addr", int'(rd_addr), 0);
    reset = 1'b0;
    repeat (3) @(negedge CLK);

    // Directed pattern A5 3C.
    mem[0] = 8'hA5; mem[1] = 8'h3C;
    run_line(1);

    // Random lines with random motor latency.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
      run_line(int'($urandom_range(1, 4)));
    end

    // start held high: back-to-back lines; mid-line start pulses ignored.
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
    step_delay = 1;
    exp_q.push_back(model_line(1, -1));
    exp_q.push_back(model_line(1, 1));
    lines_target += 2;
    @(negedge CLK); start = 1'b1;
    n = 0;
    while (!done && n < 500) begin @(negedge CLK); n++; end
    dchk("held_first_done", int'(done), 1);
    n = 0;
    while (!busy && n < 5) begin @(negedge CLK); n++; end
    dchk("held_second_busy", int'(busy), 1);
    start = 1'b0;
    repeat (20) @(negedge CLK);
    start = 1'b1; @(negedge CLK); start = 1'b0;
    repeat (30) @(negedge CLK);
    start = 1'b1; @(negedge CLK); start = 1'b0;
    wait_lines(lines_target, 2000);
    repeat (4) @(negedge CLK);

    // Abort on the 5th STB cycle.
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
    step_delay = 1;
    e = model_line(1, -1);
    e.completed = 1'b0; e.stb = 5; e.steps = 0;
    exp_q.push_back(e);
    lines_target++;
    pulse_start();
    n = 0;
    while (!STB && n < 500) begin @(negedge CLK); n++; end
    repeat (4) @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    dchk("abort_stb", int'(STB), 0);
    dchk("abort_busy", int'(busy), 0);
    wait_lines(lines_target, 100);
    repeat (4) @(negedge CLK);

    // Asynchronous reset in the middle of SHIFT.
    mem[0] = 8'hFF; mem[1] = 8'hFF;
    pulse_start();
    repeat (8) @(negedge CLK);
    dchk("pre_rst_busy", int'(busy), 1);
    dchk("pre_rst_do", int'(DO), 1);
    @(posedge CLK);
    #3 reset = 1'b1;
    #1;
    dchk("async_rst_outputs", int'({DO, CLKimpr, LAT, STB, step_req, busy, done}), 0);
    dchk("async_rst_addr", int'(rd_addr), 0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    repeat (4) @(negedge CLK);

    // Blank line.
    mem[0] = 8'h00; mem[1] = 8'h00;
    run_line(1);

    // Slow motor.
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
    run_line(100);

    // Stray step_done while idle.
    poke_cnt++;
    repeat (10) @(negedge CLK);
    dchk("idle_stepdone_busy", int'(busy), 0);

    repeat (5) @(negedge CLK);
    dchk("scoreboard_empty", exp_q.size(), 0);
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
